mult_accum_datapath: RTL and testbench

//  Datapath driven by multiplier_controller in the 8x8 multiplier.

---
 rtl/mult_accum_datapath.sv | 78 +++++++
 tb/tb_mult_accum_datapath.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult_accum_datapath.sv
// Nibble-serial 8x8 multiply datapath: selects a 4x4 partial product, shifts it into
// place, accumulates it, and latches the finished product when the controller signals done.
module mult_accum_datapath #(
  parameter int unsigned W_OP   = 8,
  parameter int unsigned W_PROD = 16
) (
  input  logic              clk,
  input  logic              reset_a,
  input  logic [W_OP-1:0]   dataa,
  input  logic [W_OP-1:0]   datab,
  input  logic [1:0]        input_sel,
  input  logic [1:0]        shift_sel,
  input  logic              clk_ena,
  input  logic              sclr_n,
  input  logic              done,
  output logic [1:0]        count,
  output logic [W_PROD-1:0] product8x8_out,
  output logic              product_valid
);

  logic [3:0]        w_nib_a;
  logic [3:0]        w_nib_b;
  logic [7:0]        w_pp;
  logic [W_PROD-1:0] w_pp_ext;
  logic [W_PROD-1:0] w_shifted;

  logic [W_PROD-1:0] r_acc;
  logic [1:0]        r_count;
  logic [W_PROD-1:0] r_product;
  logic              r_valid;

  // The nibble split below is hard-wired for 8-bit operands.
  always_ff @(posedge clk) begin
    assert (W_OP == 8 && W_PROD == 2 * W_OP)
      else $error("mult_accum_datapath: W_OP must be 8 and W_PROD must be 16");
  end

  always_comb begin
    w_nib_a = input_sel[1] ? dataa[7:4] : dataa[3:0];
    w_nib_b = input_sel[0] ? datab[7:4] : datab[3:0];
    w_pp    = {4'b0000, w_nib_a} * {4'b0000, w_nib_b};
    w_pp_ext = {{(W_PROD-8){1'b0}}, w_pp};
    case (shift_sel)
      2'b01:   w_shifted = w_pp_ext << 4;
      2'b10:   w_shifted = w_pp_ext << 8;
      default: w_shifted = w_pp_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (!sclr_n) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (clk_ena) begin
      r_acc   <= r_acc + w_shifted;
      r_count <= r_count + 2'd1;
    end
  end

  // Latch samples the accumulator before this edge's clear/accumulate takes effect.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_product <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= done;
      if (done) r_product <= r_acc;
    end
  end

  assign count          = r_count;
  assign product8x8_out = r_product;
  assign product_valid  = r_valid;

endmodule

// File: tb/tb_mult_accum_datapath.sv
// Randomized self-checking bench for mult_accum_datapath against an arithmetic model.
module tb_mult_accum_datapath;

  logic        clk = 1'b0;
  logic        reset_a;
  logic [7:0]  dataa, datab;
  logic [1:0]  input_sel, shift_sel;
  logic        clk_ena, sclr_n, done;
  logic [1:0]  count;
  logic [15:0] product8x8_out;
  logic        product_valid;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int unsigned m_acc, m_count, m_prod;
  logic        m_valid;

  mult_accum_datapath #(.W_OP(8), .W_PROD(16)) dut (
    .clk(clk), .reset_a(reset_a), .dataa(dataa), .datab(datab),
    .input_sel(input_sel), .shift_sel(shift_sel), .clk_ena(clk_ena),
    .sclr_n(sclr_n), .done(done), .count(count),
    .product8x8_out(product8x8_out), .product_valid(product_valid)
  );

  always #5 clk = ~clk;

  function automatic int unsigned partial(input int unsigned a, input int unsigned b,
                                          input int unsigned sel, input int unsigned sh);
    int unsigned na, nb, p;
    na = (sel >= 2) ? (a / 16) : (a % 16);
    nb = (sel % 2 == 1) ? (b / 16) : (b % 16);
    p  = na * nb;
    if (sh == 1) p = p * 16;
    else if (sh == 2) p = p * 256;
    return p;
  endfunction

  // Apply one clock with the given controls, then advance the model by spec rules.
  task automatic cycle(input logic rst, input logic clr_n, input logic ena, input logic dn,
                       input logic [1:0] sel, input logic [1:0] sh);
    reset_a = rst; sclr_n = clr_n; clk_ena = ena; done = dn;
    input_sel = sel; shift_sel = sh;
    @(posedge clk);
    #1;
    if (rst) begin
      m_acc = 0; m_count = 0; m_prod = 0; m_valid = 1'b0;
    end else begin
      m_valid = dn;
      if (dn) m_prod = m_acc;
      if (!clr_n) begin
        m_acc = 0; m_count = 0;
      end else if (ena) begin
        m_acc   = (m_acc + partial(dataa, datab, sel, sh)) % 65536;
        m_count = (m_count + 1) % 4;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      dataa = 8'($urandom); datab = 8'($urandom);
      cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
      n_total++;
      if (count !== 2'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
      n_total++;
      if (product8x8_out !== 16'h0) $display("FAIL reset_product: got %h want 0000", product8x8_out); else n_pass++;
      n_total++;
      if (product_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", product_valid); else n_pass++;
    end
  endtask

  // Full legal multiply: clear, four partials, done; product must equal a*b.
  task automatic test_multiply(input logic [7:0] a, input logic [7:0] b);
    logic [1:0] sels[4]   = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] shifts[4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    int unsigned want;
    dataa = a; datab = b;
    want = (32'(a) * 32'(b)) % 65536;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    n_total++;
    if (count !== 2'd0) $display("FAIL mul_clear_count: got %0d want 0", count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, sels[i], shifts[i]);
      n_total++;
      if (count !== 2'((i + 1) % 4)) $display("FAIL mul_count[%0d]: got %0d want %0d", i, count, (i + 1) % 4);
      else n_pass++;
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    n_total++;
    if (product8x8_out !== 16'(want)) $display("FAIL mul_product %h*%h: got %h want %h", a, b, product8x8_out, want);
    else n_pass++;
    n_total++;
    if (product_valid !== 1'b1) $display("FAIL mul_valid_pulse: got %b want 1", product_valid); else n_pass++;
    idle();
    n_total++;
    if (product_valid !== 1'b0) $display("FAIL mul_valid_drop: got %b want 0", product_valid); else n_pass++;
    n_total++;
    if (product8x8_out !== 16'(want)) $display("FAIL mul_product_hold: got %h want %h", product8x8_out, want); else n_pass++;
  endtask

  task automatic test_hold();
    dataa = 8'h12; datab = 8'h34;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'($urandom), 2'($urandom));
      n_total++;
      if (count !== 2'd2) $display("FAIL hold_count[%0d]: got %0d want 2", i, count); else n_pass++;
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 2'd2);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    n_total++;
    if (product8x8_out !== 16'h03A8) $display("FAIL hold_product: got %h want 03a8", product8x8_out); else n_pass++;
  endtask

  task automatic test_reset_mid();
    dataa = 8'hA7; datab = 8'h5C;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1);
    n_total++;
    if (count !== 2'd0) $display("FAIL rstmid_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if (product8x8_out !== 16'h0) $display("FAIL rstmid_product: got %h want 0000", product8x8_out); else n_pass++;
    // Only the post-reset partial survives: a[7:4]*b[7:4] << 8 = 0xA*0x5 << 8
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 2'd2);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    n_total++;
    if (product8x8_out !== 16'h3200) $display("FAIL rstmid_partial: got %h want 3200", product8x8_out); else n_pass++;
  endtask

  task automatic test_clear_priority();
    dataa = 8'hFF; datab = 8'hFF;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 2'd2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    n_total++;
    if (count !== 2'd0) $display("FAIL clr_over_ena_count: got %0d want 0", count); else n_pass++;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    // done together with clear: old acc (0xE1) latched, then acc cleared
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    n_total++;
    if (product8x8_out !== 16'h00E1) $display("FAIL done_clr_product: got %h want 00e1", product8x8_out); else n_pass++;
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    n_total++;
    if (product8x8_out !== 16'h0000) $display("FAIL done_clr_after: got %h want 0000", product8x8_out); else n_pass++;
    // done together with enable: pre-update acc latched
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0);
    n_total++;
    if (product8x8_out !== 16'h0000) $display("FAIL done_ena_product: got %h want 0000", product8x8_out); else n_pass++;
    n_total++;
    if (count !== 2'd1) $display("FAIL done_ena_count: got %0d want 1", count); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin dataa = 8'($urandom); datab = 8'($urandom); end
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0), 1'($urandom),
            ($urandom_range(0, 5) == 0), 2'($urandom), 2'($urandom));
      n_total++;
      if (count !== 2'(m_count) || product8x8_out !== 16'(m_prod) || product_valid !== m_valid)
        $display("FAIL random[%0d]: got cnt=%0d prod=%h vld=%b want cnt=%0d prod=%h vld=%b",
                 i, count, product8x8_out, product_valid, m_count, m_prod[15:0], m_valid);
      else n_pass++;
    end
  endtask

  initial begin
    reset_a = 1'b1; sclr_n = 1'b1; clk_ena = 1'b0; done = 1'b0;
    input_sel = '0; shift_sel = '0; dataa = '0; datab = '0;
    m_acc = 0; m_count = 0; m_prod = 0; m_valid = 1'b0;
    test_reset();
    test_multiply(8'hFF, 8'hFF);
    test_multiply(8'h12, 8'h34);
    for (int i = 0; i < 4; i++) test_multiply(8'($urandom), 8'($urandom));
    test_hold();
    test_reset_mid();
    test_clear_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
